// File: rtl/spi_display_receiver.sv
// SPI slave decoding 16-bit MAX7219-style frames into a display register file.
// All logic runs on clk; sck/mosi/cs are synchronised before use.
module spi_display_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_DIGITS  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sck,
  input  logic                    mosi,
  input  logic                    cs,
  output logic                    frame_valid,
  output logic                    frame_error,
  output logic [3:0]              frame_addr,
  output logic [7:0]              frame_data,
  output logic [8*NUM_DIGITS-1:0] digits,
  output logic [7:0]              decode_mode,
  output logic [3:0]              intensity,
  output logic [2:0]              scan_limit,
  output logic                    shutdown_n,
  output logic                    display_test
);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT, COMMIT} state_t;

  state_t state, next_state;

  logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, cs_sync;
  logic sck_s, mosi_s, cs_s, sck_prev, cs_prev;
  logic sck_rise, cs_rise, cs_fall;
  logic [15:0] shreg;
  logic [4:0]  bit_cnt;
  logic        good_frame;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= '0;
      mosi_sync <= '0;
      cs_sync   <= '0;
      sck_prev  <= 1'b0;
      cs_prev   <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      sck_prev  <= sck_s;
      cs_prev   <= cs_s;
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev;
  assign cs_rise  = cs_s & ~cs_prev;
  assign cs_fall  = ~cs_s & cs_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      WAIT_IDLE: if (cs_s)    next_state = IDLE;
      IDLE:      if (cs_fall) next_state = SHIFT;
      SHIFT:     if (cs_rise) next_state = COMMIT;
      COMMIT:                 next_state = IDLE;
      default:                next_state = WAIT_IDLE;
    endcase
  end

  assign good_frame  = (bit_cnt == 5'd16);
  assign frame_valid = (state == COMMIT) && good_frame;
  assign frame_error = (state == COMMIT) && !good_frame;

  // A bit count above 16 saturates at 17 so overlong frames stay distinguishable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg        <= '0;
      bit_cnt      <= '0;
      frame_addr   <= '0;
      frame_data   <= '0;
      digits       <= '0;
      decode_mode  <= '0;
      intensity    <= '0;
      scan_limit   <= '0;
      shutdown_n   <= 1'b0;
      display_test <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cs_fall) begin
            shreg   <= '0;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (sck_rise) begin
            shreg <= {shreg[14:0], mosi_s};
            if (bit_cnt != 5'd17) bit_cnt <= bit_cnt + 5'd1;
          end
        end
        COMMIT: begin
          if (good_frame) begin
            frame_addr <= shreg[11:8];
            frame_data <= shreg[7:0];
            for (int i = 0; i < NUM_DIGITS; i++) begin
              if (shreg[11:8] == 4'(i + 1)) digits[8*i +: 8] <= shreg[7:0];
            end
            case (shreg[11:8])
              4'h9: decode_mode  <= shreg[7:0];
              4'hA: intensity    <= shreg[3:0];
              4'hB: scan_limit   <= shreg[2:0];
              4'hC: shutdown_n   <= shreg[0];
              4'hF: display_test <= shreg[0];
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule
